mpsoc_msi_master_switch_ctrl: RTL
=================================

# mpsoc_msi_master_switch_ctrl

Per-master burst/lock tracker for the MSI interconnect. One instance sits on each AHB master's path into the slave-port arbiters. It watches that master's address-phase signals and drives one `can_switch` bit per slave port. An arbiter may move its grant away from this master only when the corresponding bit is high, so fixed-length bursts and locked sequences are never split.

## Interface
Parameters:
- `SLAVES`, 5, number of slave ports, which is the width of `HSEL` and `can_switch`.
- `MAX_INCR_BEATS`, 16, beat limit for undefined-length INCR bursts; used only with `MPSOC_MSI_INCR_LIMIT_EN`.

Ports:
- `HCLK`  in  1  bus clock; all state changes on the rising edge.
- `HRESET`  in  1  asynchronous, active-high reset.
- `HSEL`  in  SLAVES  one-hot decoded slave selection for the current address phase.
- `HTRANS`  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HBURST`  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- `HMASTLOCK`  in  1  locked sequence request.
- `HREADY`  in  1  ready returned to this master; the address phase is accepted when `HREADY`=1.
- `can_switch`  out  SLAVES  per slave; 1 means the arbiter may regrant on this edge.
- `burst_active`  out  1  state is BURST, INCR or LOCKED.
- `beats_left`  out  5  remaining fixed-burst beats after the current one.

## Operation
- Accepted transfer: `HREADY`=1 and `HTRANS[1]`=1 and `HSEL`≠0. `owner` is the index of `HSEL`, registered on acceptance.
- Default: `can_switch` = all ones. Only the `owner` bit, or the `HSEL` bit on a starting transfer, is ever cleared. This output is combinational from the registered state and the current inputs.
- States: IDLE, BURST (fixed length), INCR (undefined length), LOCKED.
- IDLE:
  - Accepted NONSEQ with `HMASTLOCK`=1 goes to LOCKED.
  - Otherwise, accepted NONSEQ with a fixed burst goes to BURST, loading `beats_left` = len−1 (3, 7 or 15).
  - Otherwise, accepted NONSEQ with INCR goes to INCR.
  - In all three cases the `HSEL` bit of `can_switch` is 0 in the accepting cycle.
  - SINGLE stays in IDLE with all bits 1.
- BURST:
  - An accepted SEQ decrements `beats_left`.
  - The `owner` bit is 0, except in the cycle where an accepted SEQ has `beats_left`=1. That cycle is the last beat: the bit is 1 and the next state is IDLE.
  - BUSY holds the count and keeps the bit at 0.
- INCR:
  - The `owner` bit is 0 while `HTRANS` ∈ {BUSY, SEQ}.
  - IDLE or NONSEQ ends the burst: the bit is 1 in that cycle, and the new transfer is evaluated as from IDLE.
- LOCKED:
  - The `owner` bit is 0 while `HMASTLOCK`=1.
  - The first accepted transfer, or an IDLE with `HREADY`=1, seen with `HMASTLOCK`=0 returns to IDLE with the bit at 1.
- Early termination in BURST:
  - `HTRANS`=IDLE, or NONSEQ (ERROR retry), aborts to IDLE.
  - The `owner` bit is 1 in that cycle, and a NONSEQ restarts evaluation.
- SEQ whose `HSEL` differs from `owner` (burst crossing a slave boundary):
  - The old `owner` bit is 1.
  - `owner` is updated, the new bit is 0, and `beats_left` continues.
- `HSEL`=0 with active `HTRANS` is not accepted; state is held.

## Timing
- Reset: state=IDLE, `beats_left`=0, `owner`=0, `burst_active`=0.
- `can_switch` is forced to all ones while `HRESET`=1.
- Reset asserted mid-burst abandons the burst immediately. The tracker restarts in IDLE.
- `can_switch` has zero latency relative to the accepting `HREADY` edge. The arbiter samples it on the same edge.
- `burst_active` and `beats_left` are registered, valid one cycle after acceptance.
- When `HREADY`=0, all state is held and `can_switch` reflects the held state.
- `beats_left` is unsigned 5 bit. It never wraps below 0; a SEQ received at 0 is treated as an abort.

## Configuration
- `MPSOC_MSI_INCR_LIMIT_EN` defined:
  - INCR state counts accepted beats.
  - On the accepted beat that reaches `MAX_INCR_BEATS`, the `owner` bit is 1 for that cycle and the counter clears. State stays INCR.
  - The arbiter may therefore preempt long INCR bursts.
- Not defined: INCR bursts are never split, and no counter is synthesized.

## Structure
- Shared package `mpsoc_msi_pkg`:
  - HTRANS and HBURST localparams.
  - State enum `msi_sw_state_t`.
  - Function `burst_beats(hburst)` returning 1, 4, 8, 16 or 0 for INCR.
- One sub-module, `mpsoc_msi_beat_counter`: load/decrement/hold counter with an `is_last` flag. It is reused for the INCR limit.

## Test plan
- Reset then SINGLE NONSEQ to slave 2 with `HREADY`=1 → `can_switch`=5'b11111 every cycle; `burst_active` stays 0.
- INCR4 to slave 1 with no waits → `can_switch[1]`=0 on beats 1–3 and 1 on beat 4. `beats_left` sequence 3,2,1,0; IDLE afterwards.
- INCR8 to slave 0 with BUSY on beat 3 and `HREADY`=0 for 2 cycles on beat 5 → count held during BUSY and wait cycles. `can_switch[0]`=1 only on the accepted 8th beat.
- Locked NONSEQ+SEQ×3 to slave 3 with `HMASTLOCK`=1, then NONSEQ with `HMASTLOCK`=0 → `can_switch[3]`=0 throughout the lock; 1 on the unlocking transfer.
- WRAP16 aborted by NONSEQ after beat 6 → `can_switch` bit 1 in the abort cycle; new burst tracked from IDLE.
- With `MPSOC_MSI_INCR_LIMIT_EN` and `MAX_INCR_BEATS`=4, INCR of 10 beats to slave 4 → `can_switch[4]`=1 on beats 4 and 8 only. Without the macro, it is 1 only after the burst ends.

Source files
------------

// File: rtl/mpsoc_msi_pkg.sv
// Shared AHB encodings, tracker state type and burst-length helper for the MSI interconnect.
package mpsoc_msi_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_INCR,
    ST_LOCKED
  } msi_sw_state_t;

  // Fixed burst length in beats; 0 marks the undefined-length INCR burst.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE:              burst_beats = 5'd1;
      HBURST_INCR:                burst_beats = 5'd0;
      HBURST_WRAP4, HBURST_INCR4: burst_beats = 5'd4;
      HBURST_WRAP8, HBURST_INCR8: burst_beats = 5'd8;
      default:                    burst_beats = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mpsoc_msi_beat_counter.sv
// Load / decrement / hold beat counter; is_last flags a count of exactly one.
module mpsoc_msi_beat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_last
);

  // Load wins over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign is_last = (count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mpsoc_msi_master_switch_ctrl.sv
// Per-master burst/lock tracker: drives per-slave can_switch so arbiters never split bursts or locks.
// Optional MPSOC_MSI_INCR_LIMIT_EN releases the slave every MAX_INCR_BEATS beats of an INCR burst.
module mpsoc_msi_master_switch_ctrl
  import mpsoc_msi_pkg::*;
#(
  parameter int SLAVES         = 5,
  parameter int MAX_INCR_BEATS = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [SLAVES-1:0] HSEL,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HBURST,
  input  logic              HMASTLOCK,
  input  logic              HREADY,
  output logic [SLAVES-1:0] can_switch,
  output logic              burst_active,
  output logic [4:0]        beats_left
);

  localparam int OW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  if (MAX_INCR_BEATS < 2 || MAX_INCR_BEATS > 31) begin : g_bad_limit
    $error("MAX_INCR_BEATS must be within 2..31");
  end

  msi_sw_state_t state, state_nxt;
  logic [OW-1:0] owner, owner_nxt, sel_idx, clr_idx;
  logic          accepted, is_nonseq, is_seq, is_idle;
  logic          clr_en, restart, ending;
  logic          cnt_load, cnt_dec;
  logic [4:0]    cnt_val, fix_len;
  logic          cnt_last;

  assign accepted  = HREADY && HTRANS[1] && (HSEL != '0);
  assign is_nonseq = (HTRANS == HTRANS_NONSEQ);
  assign is_seq    = (HTRANS == HTRANS_SEQ);
  assign is_idle   = (HTRANS == HTRANS_IDLE);
  assign fix_len   = burst_beats(HBURST);

  always_comb begin
    sel_idx = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (HSEL[i]) sel_idx = OW'(i);
    end
  end

`ifdef MPSOC_MSI_INCR_LIMIT_EN
  logic       lim_load, lim_dec, lim_last;
  logic [4:0] lim_val, lim_count;

  mpsoc_msi_beat_counter #(.W(5)) u_incr_lim (
    .clk(HCLK), .rst(HRESET), .load(lim_load), .load_val(lim_val),
    .dec(lim_dec), .count(lim_count), .is_last(lim_last)
  );
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = accepted ? sel_idx : owner;
    clr_en    = 1'b0;
    clr_idx   = owner;
    restart   = 1'b0;
    ending    = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = 5'd0;
    cnt_dec   = 1'b0;
`ifdef MPSOC_MSI_INCR_LIMIT_EN
    lim_load  = 1'b0;
    lim_val   = 5'd0;
    lim_dec   = 1'b0;
`endif
    case (state)
      ST_IDLE: restart = 1'b1;
      ST_BURST: begin
        clr_en = 1'b1;
        // IDLE, NONSEQ retry, the last beat, or a SEQ at zero all release the slave.
        if ((HREADY && is_idle) || (accepted && is_nonseq) ||
            (accepted && is_seq && (cnt_val <= beats_left) && (beats_left <= 5'd1))) begin
          clr_en    = 1'b0;
          ending    = 1'b1;
          restart   = 1'b1;
          state_nxt = ST_IDLE;
          cnt_load  = 1'b1;
        end else if (accepted && is_seq) begin
          cnt_dec = 1'b1;
          clr_idx = sel_idx;
        end
      end
      ST_INCR: begin
        clr_en = 1'b1;
        if ((HREADY && is_idle) || (accepted && is_nonseq)) begin
          clr_en    = 1'b0;
          ending    = 1'b1;
          restart   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (accepted && is_seq) begin
          clr_idx = sel_idx;
`ifdef MPSOC_MSI_INCR_LIMIT_EN
          if (lim_last) begin
            clr_en   = 1'b0;
            lim_load = 1'b1;
            lim_val  = 5'(MAX_INCR_BEATS);
          end else begin
            lim_dec = 1'b1;
          end
`endif
        end
      end
      default: begin
        clr_en = 1'b1;
        if (HREADY && !HMASTLOCK && (accepted || is_idle)) begin
          clr_en    = 1'b0;
          ending    = 1'b1;
          restart   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (accepted) begin
          clr_idx = sel_idx;
        end
      end
    endcase

    // A cycle that ends a burst or lock keeps every bit high even if a new burst starts on it.
    if (restart && accepted && is_nonseq) begin
      if (HMASTLOCK) begin
        state_nxt = ST_LOCKED;
      end else if (fix_len > 5'd1) begin
        state_nxt = ST_BURST;
        cnt_load  = 1'b1;
        cnt_val   = fix_len - 5'd1;
      end else if (HBURST == HBURST_INCR) begin
        state_nxt = ST_INCR;
`ifdef MPSOC_MSI_INCR_LIMIT_EN
        lim_load  = 1'b1;
        lim_val   = 5'(MAX_INCR_BEATS - 1);
`endif
      end
      if (!ending && (state_nxt != ST_IDLE)) begin
        clr_en  = 1'b1;
        clr_idx = sel_idx;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  mpsoc_msi_beat_counter #(.W(5)) u_beats (
    .clk(HCLK), .rst(HRESET), .load(cnt_load), .load_val(cnt_val),
    .dec(cnt_dec), .count(beats_left), .is_last(cnt_last)
  );

  always_comb begin
    can_switch = '1;
    if (!HRESET && clr_en) can_switch[clr_idx] = 1'b0;
  end

  assign burst_active = (state != ST_IDLE);

endmodule
